valid_ready_arbiter: RTL and testbench
======================================

# valid_ready_arbiter

Round-robin arbiter that shares one valid/ready address/data channel between NREQ requesters. Each requester hands a transfer over on its own valid/ready port. The arbiter registers the winning payload and drives it onto the shared channel. It holds `valid` and the payload stable until the sink asserts `ready`, and forces `valid` low for at least one cycle after every completed handshake, so each transfer is a distinct `$rose(valid)` event.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 2: address width.
- `DW`, 4: data width.
- `TIMEOUT`, 16: consecutive stalled cycles in SEND before `timeout_err` sets (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester transfer request.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_addr`  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed data; requester i at bits [i*DW +: DW].
- `valid`  out  1  shared-channel valid.
- `ready`  in  1  shared-channel ready from sink.
- `addr`  out  AW  shared-channel address.
- `data`  out  DW  shared-channel data.
- `grant_id`  out  $clog2(NREQ)  index of the requester whose payload is on the channel.
- `busy`  out  1  high in SEND.
- `timeout_err`  out  1  sticky stall flag.

## Operation
- FSM states:
  - IDLE: `valid`=0.
  - SEND: `valid`=1.
- IDLE:
  - Arbitrate only when any `req_valid` bit is set.
  - Winner g is the first set bit searching upward from `last+1`, modulo NREQ.
  - `req_ready[g]`=1 combinationally in the same cycle; all other `req_ready` bits are 0.
  - At the clock edge, capture `req_addr[g]`/`req_data[g]` into `addr`/`data`, load `grant_id`=g and `last`=g, clear the stall counter, and go to SEND.
- SEND:
  - `req_ready` is all zero.
  - `valid`, `addr`, `data` and `grant_id` stay constant.
  - If `ready`=1 at the edge, the handshake completes and the FSM goes to IDLE.
  - If `ready`=0, the stall counter increments, saturating at TIMEOUT.
- The cycle after a handshake is always IDLE with `valid`=0. There is no back-to-back valid, so the minimum transfer period is 2 cycles.
- `timeout_err`:
  - Set when the stall counter reaches TIMEOUT.
  - Remains set until reset.
  - Does not abort the transfer: `valid` stays high until `ready`.
- Requester rules: a requester may withdraw `req_valid` before being granted; nothing is captured for it. `req_ready` is never asserted to a requester whose `req_valid`=0.
- Width rules:
  - `grant_id` is zero-extended.
  - The pointer wraps from NREQ-1 to 0.
  - The stall counter is $clog2(TIMEOUT+1) bits wide and never wraps.

## Timing
- Reset (async, while `rst`=0):
  - State = IDLE.
  - Outputs: `valid`=0, `addr`=0, `data`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, `req_ready`=0.
  - Internal: `last`=NREQ-1, so requester 0 has first priority; stall counter = 0.
- Reset mid-SEND: `valid` drops immediately (asynchronously) and the payload is discarded. After release, the FSM resumes in IDLE.
- Latency:
  - Requester handshake (`req_valid` & `req_ready` at edge N) → `valid`=1 at cycle N+1.
  - With `ready` held high, channel handshake at edge N+1 → `valid`=0 at N+2; the next grant is possible at N+2.
- Simultaneous requests: exactly one winner per IDLE cycle. The others wait; with all requesters active, the sequence is 0,1,2,3,0,...
- `ready` asserted while in IDLE is ignored.
- `timeout_err` rises at the edge that ends the TIMEOUT-th consecutive `ready`=0 cycle in SEND.

## Test plan
- Single request, sink always ready: requester 2 sends addr=1, data=0xA → `req_ready[2]` pulses 1 cycle; next cycle `valid`=1, `addr`=1, `data`=0xA, `grant_id`=2; the following cycle `valid`=0.
- Sink stall: `ready`=0 for 3 cycles, then 1 → `valid` high for 4 cycles, payload constant throughout, `valid` low the cycle after `ready`, `timeout_err`=0.
- Fairness: all 4 `req_valid` held high for 8 transfers, `ready`=1 → grant order 0,1,2,3,0,1,2,3; `valid` alternates 1/0 every cycle.
- Timeout: TIMEOUT=16, `ready`=0 for 20 cycles in SEND → `timeout_err` sets after the 16th stall, `valid` still 1; after `ready`, the transfer completes and `timeout_err` stays 1.
- Reset mid-transfer: deassert `rst` during SEND → `valid`, `busy` and `req_ready` go 0 without waiting for a clock edge; after release, requester 0 wins first.
- Withdrawn request: requester 1 raises then drops `req_valid` while another transfer is in SEND → no `req_ready[1]` pulse and no transfer with `grant_id`=1.

Source files
------------

// File: rtl/valid_ready_arbiter.sv
`default_nettype none
// ============================================================================
// valid_ready_arbiter : round-robin arbiter onto one registered valid/ready
//                       channel, valid dropped for one cycle after every handshake.
// Revision 1.0
// ============================================================================
module valid_ready_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 2,
  parameter int DW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic                    valid,
  input  logic                    ready,
  output logic [AW-1:0]           addr,
  output logic [DW-1:0]           data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   stall_cnt;
  logic            take;

  // Search upward from last+1 with explicit wrap so non-power-of-two NREQ works.
  always_comb begin : p_arb
    logic [IW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Gated by rst so no requester sees an accept while reset is held.
  assign take = (state == IDLE) && found && rst;

  always_comb begin
    req_ready = '0;
    if (take) begin
      req_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take)  state_next = SEND;
      SEND:    if (ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr        <= '0;
      data        <= '0;
      grant_id    <= '0;
      last        <= IW'(NREQ - 1);
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (take) begin
        addr      <= req_addr[win*AW +: AW];
        data      <= req_data[win*DW +: DW];
        grant_id  <= win;
        last      <= win;
        stall_cnt <= '0;
      end else if (state == SEND && !ready) begin
        if (stall_cnt != CW'(TIMEOUT)) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (stall_cnt == CW'(TIMEOUT - 1)) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  assign valid = (state == SEND);
  assign busy  = (state == SEND);

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_arbiter.sv
`default_nettype none
// ============================================================================
// tb_valid_ready_arbiter : directed scenario bench for valid_ready_arbiter.
// Revision 1.0
// ============================================================================
module tb_valid_ready_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        valid;
  logic        ready;
  logic [1:0]  addr;
  logic [3:0]  data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  valid_ready_arbiter #(.NREQ(4), .AW(2), .DW(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .valid      (valid),
    .ready      (ready),
    .addr       (addr),
    .data       (data),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 4'b1111;
    #3;
    n_cmp++;
    if ({valid, addr, data, grant_id, busy, timeout_err, req_ready} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want all zero",
               {valid, addr, data, grant_id, busy, timeout_err, req_ready});
    end
    req_valid = 4'b0000;
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_single;
    ready = 1'b1; req_addr = 8'h10; req_data = 16'h0A00; req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL single_req_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if ({valid, addr, data, grant_id, busy, req_ready} !== {1'b1, 2'd1, 4'hA, 2'd2, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL single_send: got v=%b a=%h d=%h g=%0d busy=%b rr=%b want v=1 a=1 d=a g=2 busy=1 rr=0000",
               valid, addr, data, grant_id, busy, req_ready);
    end
    tick();
    n_cmp++;
    if ({valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL single_drop: got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_stall;
    ready = 1'b0; req_addr = 8'h03; req_data = 16'h0005; req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL stall_req_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) ready = 1'b1;
      #1;
      n_cmp++;
      if ({valid, addr, data, grant_id} !== {1'b1, 2'd3, 4'h5, 2'd0}) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got v=%b a=%h d=%h g=%0d want v=1 a=3 d=5 g=0",
                 c, valid, addr, data, grant_id);
      end
      tick();
    end
    ready = 1'b0;
    n_cmp++;
    if ({valid, timeout_err} !== 2'b00) begin
      n_err++; $display("FAIL stall_end: got valid=%b terr=%b want 0 0", valid, timeout_err);
    end
  endtask

  task automatic test_fairness;
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] exp_rr;
    do_reset();
    ready = 1'b1; req_addr = 8'hE4; req_data = 16'hBA98; req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_rr = 4'b0001 << exp_g[i];
      #1;
      n_cmp++;
      if ({valid, req_ready} !== {1'b0, exp_rr}) begin
        n_err++;
        $display("FAIL fair_idle_%0d: got v=%b rr=%b want v=0 rr=%b", i, valid, req_ready, exp_rr);
      end
      tick();
      n_cmp++;
      if ({valid, grant_id, addr, data} !== {1'b1, 2'(exp_g[i]), 2'(exp_g[i]), 4'(exp_g[i] + 8)}) begin
        n_err++;
        $display("FAIL fair_send_%0d: got v=%b g=%0d a=%0d d=%h want v=1 g=%0d a=%0d d=%h",
                 i, valid, grant_id, addr, data, exp_g[i], exp_g[i], exp_g[i] + 8);
      end
      tick();
    end
    req_valid = 4'b0000;
    ready = 1'b0;
  endtask

  task automatic test_timeout;
    ready = 1'b0; req_addr = 8'h08; req_data = 16'h00C0; req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++;
      if ({valid, grant_id, timeout_err} !== {1'b1, 2'd1, (i >= 16)}) begin
        n_err++;
        $display("FAIL timeout_stall_%0d: got v=%b g=%0d terr=%b want v=1 g=1 terr=%b",
                 i, valid, grant_id, timeout_err, (i >= 16));
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++;
    if ({valid, timeout_err} !== 2'b01) begin
      n_err++; $display("FAIL timeout_sticky: got valid=%b terr=%b want 0 1", valid, timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    ready = 1'b0; req_addr = 8'hE4; req_data = 16'hBA98; req_valid = 4'b0100;
    tick();
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if ({valid, grant_id} !== {1'b1, 2'd2}) begin
      n_err++; $display("FAIL rstmid_pre: got v=%b g=%0d want v=1 g=2", valid, grant_id);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({valid, busy, req_ready, timeout_err, grant_id} !== 9'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b busy=%b rr=%b terr=%b g=%0d want all zero",
               valid, busy, req_ready, timeout_err, grant_id);
    end
    #10 rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rstmid_first_rr: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if ({valid, grant_id, addr, data} !== {1'b1, 2'd0, 2'd0, 4'h8}) begin
      n_err++;
      $display("FAIL rstmid_first_send: got v=%b g=%0d a=%0d d=%h want v=1 g=0 a=0 d=8",
               valid, grant_id, addr, data);
    end
    req_valid = 4'b0000;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_withdrawn;
    ready = 1'b0; req_addr = 8'hE4; req_data = 16'hBA98; req_valid = 4'b1000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL wd_rr3: got %b want 1000", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({valid, grant_id, req_ready} !== {1'b1, 2'd3, 4'b0000}) begin
        n_err++;
        $display("FAIL wd_send_%0d: got v=%b g=%0d rr=%b want v=1 g=3 rr=0000",
                 c, valid, grant_id, req_ready);
      end
      tick();
    end
    req_valid = 4'b0000;
    ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({valid, busy, req_ready} !== 6'd0) begin
        n_err++;
        $display("FAIL wd_idle_%0d: got v=%b busy=%b rr=%b want 0 0 0000", c, valid, busy, req_ready);
      end
      tick();
    end
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_stall();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_withdrawn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
